// File: rtl/mpu_matrix_loader.sv
// Packs a sized stream of int8 elements into a zero-filled 5x5 matrix bus.
// MPU_LOADER_TRANSPOSE_EN adds a transpose port for column-major streams.
module mpu_matrix_loader #(
  parameter int MAX_N  = 5,
  parameter int ELEM_W = 8
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              start,
  input  logic [7:0]                        size,
  output logic                              start_ready,
  output logic                              size_err,
`ifdef MPU_LOADER_TRANSPOSE_EN
  input  logic                              transpose,
`endif
  input  logic signed [ELEM_W-1:0]          in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [0:ELEM_W*MAX_N*MAX_N-1]     matrix,
  output logic [7:0]                        matrix_size,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              busy
);

  localparam int CW     = $clog2(MAX_N + 1);
  localparam int SIZE_W = 8;
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD
  } state_t;

  state_t r_state;
  state_t w_next;

  logic signed [ELEM_W-1:0] r_cells [MAX_N][MAX_N];
  logic [CW-1:0] r_n;
  logic [CW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic          r_size_err;
  logic          r_tr;

  logic          w_size_in;
  logic          w_start_ok;
  logic          w_start_bad;
  logic          w_acc;
  logic          w_last;
  logic          w_tr_in;
  logic [CW-1:0] w_nm1;

`ifdef MPU_LOADER_TRANSPOSE_EN
  assign w_tr_in = transpose;
`else
  assign w_tr_in = 1'b0;
`endif

  // size is signed: reject zero, negatives and anything above MAX_N
  assign w_size_in = !size[SIZE_W-1]
                  && (size != '0)
                  && (size <= SIZE_W'(MAX_N));

  assign w_start_ok  = (r_state == S_IDLE) && start && w_size_in;
  assign w_start_bad = (r_state == S_IDLE) && start && !w_size_in;
  assign w_acc       = (r_state == S_LOAD) && in_valid;
  assign w_nm1       = r_n - ONE;
  assign w_last      = (r_row == w_nm1) && (r_col == w_nm1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_start_ok) w_next = S_LOAD;
      S_LOAD: if (w_acc && w_last) w_next = S_HOLD;
      S_HOLD: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < MAX_N; r++)
        for (int c = 0; c < MAX_N; c++)
          r_cells[r][c] <= '0;
      r_n        <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_size_err <= 1'b0;
      r_tr       <= 1'b0;
    end else begin
      r_size_err <= w_start_bad;
      if (w_start_ok) begin
        for (int r = 0; r < MAX_N; r++)
          for (int c = 0; c < MAX_N; c++)
            r_cells[r][c] <= '0;
        r_n   <= size[CW-1:0];
        r_row <= '0;
        r_col <= '0;
        r_tr  <= w_tr_in;
      end else if (w_acc) begin
        r_cells[r_row][r_col] <= in_data;
        // column-major streams run the row counter as the inner loop
        if (r_tr) begin
          if (r_row == w_nm1) begin
            r_row <= '0;
            r_col <= r_col + ONE;
          end else begin
            r_row <= r_row + ONE;
          end
        end else begin
          if (r_col == w_nm1) begin
            r_col <= '0;
            r_row <= r_row + ONE;
          end else begin
            r_col <= r_col + ONE;
          end
        end
      end
    end
  end

  for (genvar gr = 0; gr < MAX_N; gr++) begin : g_row
    for (genvar gc = 0; gc < MAX_N; gc++) begin : g_col
      assign matrix[ELEM_W*(gc+MAX_N*gr) +: ELEM_W] = r_cells[gr][gc];
    end
  end

  assign matrix_size = {{(SIZE_W-CW){1'b0}}, r_n};
  assign start_ready = (r_state == S_IDLE);
  assign in_ready    = (r_state == S_LOAD);
  assign out_valid   = (r_state == S_HOLD);
  assign busy        = (r_state != S_IDLE);
  assign size_err    = r_size_err;

endmodule
